// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - reorder buffer with in-order retire, CDB capture and operand forwarding
module rob_commit_unit #(
    parameter int ROB_SIZE = 16,
    parameter int ROB_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_decoder_valid,
    input  logic [4:0]       in_decoder_dest_reg,
    input  logic [31:0]      in_decoder_pc,
    input  logic             in_decoder_is_branch,
    input  logic             in_decoder_pred_taken,
    input  logic             in_decoder_is_store,
    output logic [ROB_W-1:0] out_decoder_rob,
    output logic             out_full,
    input  logic [ROB_W-1:0] in_query_rob1,
    input  logic [ROB_W-1:0] in_query_rob2,
    output logic             out_query_ready1,
    output logic             out_query_ready2,
    output logic [31:0]      out_query_value1,
    output logic [31:0]      out_query_value2,
    input  logic             in_cdb_valid,
    input  logic [ROB_W-1:0] in_cdb_rob,
    input  logic [31:0]      in_cdb_value,
    input  logic             in_cdb_taken,
    input  logic [31:0]      in_cdb_target,
    output logic [4:0]       out_commit_reg,
    output logic [ROB_W-1:0] out_commit_rob,
    output logic [31:0]      out_commit_value,
    output logic             out_store_commit,
    output logic [ROB_W-1:0] out_store_rob,
    output logic             out_xbp,
    output logic [31:0]      out_xbp_pc
);
    localparam logic [ROB_W:0]   FULL_CNT = {1'b1, {ROB_W{1'b0}}};
    localparam logic [ROB_W:0]   CNT_ONE  = {{ROB_W{1'b0}}, 1'b1};
    localparam logic [ROB_W-1:0] PTR_ONE  = {{(ROB_W-1){1'b0}}, 1'b1};

    logic [ROB_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [ROB_W:0]      count_q, count_d;
    logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;
    logic [ROB_SIZE-1:0] is_branch_q, is_branch_d, pred_taken_q, pred_taken_d;
    logic [ROB_SIZE-1:0] is_store_q, is_store_d, act_taken_q, act_taken_d;
    logic [4:0]          dest_q   [ROB_SIZE];
    logic [4:0]          dest_d   [ROB_SIZE];
    logic [31:0]         value_q  [ROB_SIZE];
    logic [31:0]         value_d  [ROB_SIZE];
    logic [31:0]         pc_q     [ROB_SIZE];
    logic [31:0]         pc_d     [ROB_SIZE];
    logic [31:0]         target_q [ROB_SIZE];
    logic [31:0]         target_d [ROB_SIZE];

    logic [4:0]          commit_reg_q, commit_reg_d;
    logic [ROB_W-1:0]    commit_rob_q, commit_rob_d, store_rob_q, store_rob_d;
    logic [31:0]         commit_value_q, commit_value_d, xbp_pc_q, xbp_pc_d;
    logic                store_commit_q, store_commit_d, xbp_q, xbp_d;

    logic retire, mispredict, alloc, cdb_wr;

    assign out_full        = (count_q == FULL_CNT);
    assign out_decoder_rob = tail_q;

    // CDB bypass lets the decoder see a result in the cycle it is broadcast
    assign out_query_ready1 = (in_cdb_valid && in_cdb_rob == in_query_rob1) ? 1'b1
                            : (busy_q[in_query_rob1] & ready_q[in_query_rob1]);
    assign out_query_value1 = (in_cdb_valid && in_cdb_rob == in_query_rob1) ? in_cdb_value
                            : value_q[in_query_rob1];
    assign out_query_ready2 = (in_cdb_valid && in_cdb_rob == in_query_rob2) ? 1'b1
                            : (busy_q[in_query_rob2] & ready_q[in_query_rob2]);
    assign out_query_value2 = (in_cdb_valid && in_cdb_rob == in_query_rob2) ? in_cdb_value
                            : value_q[in_query_rob2];

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        busy_d         = busy_q;
        ready_d        = ready_q;
        is_branch_d    = is_branch_q;
        pred_taken_d   = pred_taken_q;
        is_store_d     = is_store_q;
        act_taken_d    = act_taken_q;
        dest_d         = dest_q;
        value_d        = value_q;
        pc_d           = pc_q;
        target_d       = target_q;
        commit_reg_d   = '0;
        commit_rob_d   = '0;
        commit_value_d = '0;
        store_commit_d = 1'b0;
        store_rob_d    = '0;
        xbp_d          = 1'b0;
        xbp_pc_d       = '0;

        retire     = rdy && busy_q[head_q] && ready_q[head_q];
        mispredict = retire && is_branch_q[head_q] && (act_taken_q[head_q] != pred_taken_q[head_q]);
        alloc      = rdy && in_decoder_valid && !out_full && !mispredict;
        cdb_wr     = rdy && in_cdb_valid && busy_q[in_cdb_rob] && !mispredict;

        if (cdb_wr) begin
            ready_d[in_cdb_rob]     = 1'b1;
            value_d[in_cdb_rob]     = in_cdb_value;
            act_taken_d[in_cdb_rob] = in_cdb_taken;
            target_d[in_cdb_rob]    = in_cdb_target;
        end

        if (alloc) begin
            busy_d[tail_q]       = 1'b1;
            ready_d[tail_q]      = 1'b0;
            dest_d[tail_q]       = in_decoder_dest_reg;
            pc_d[tail_q]         = in_decoder_pc;
            is_branch_d[tail_q]  = in_decoder_is_branch;
            pred_taken_d[tail_q] = in_decoder_pred_taken;
            is_store_d[tail_q]   = in_decoder_is_store;
            tail_d               = tail_q + PTR_ONE;
        end

        if (retire) begin
            commit_reg_d   = is_store_q[head_q] ? 5'd0 : dest_q[head_q];
            commit_rob_d   = head_q;
            commit_value_d = value_q[head_q];
            store_commit_d = is_store_q[head_q];
            store_rob_d    = is_store_q[head_q] ? head_q : '0;
            busy_d[head_q] = 1'b0;
            head_d         = head_q + PTR_ONE;
        end

        case ({alloc, retire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A wrong-path branch wipes every younger entry in the same edge
        if (mispredict) begin
            xbp_d    = 1'b1;
            xbp_pc_d = act_taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
            busy_d   = '0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            commit_reg_q   <= '0;
            commit_rob_q   <= '0;
            commit_value_q <= '0;
            store_commit_q <= 1'b0;
            store_rob_q    <= '0;
            xbp_q          <= 1'b0;
            xbp_pc_q       <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            commit_reg_q   <= commit_reg_d;
            commit_rob_q   <= commit_rob_d;
            commit_value_q <= commit_value_d;
            store_commit_q <= store_commit_d;
            store_rob_q    <= store_rob_d;
            xbp_q          <= xbp_d;
            xbp_pc_q       <= xbp_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        is_branch_q  <= is_branch_d;
        pred_taken_q <= pred_taken_d;
        is_store_q   <= is_store_d;
        act_taken_q  <= act_taken_d;
        dest_q       <= dest_d;
        value_q      <= value_d;
        pc_q         <= pc_d;
        target_q     <= target_d;
    end

    assign out_commit_reg   = commit_reg_q;
    assign out_commit_rob   = commit_rob_q;
    assign out_commit_value = commit_value_q;
    assign out_store_commit = store_commit_q;
    assign out_store_rob    = store_rob_q;
    assign out_xbp          = xbp_q;
    assign out_xbp_pc       = xbp_pc_q;
endmodule
